multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control unit for a multicycle RV32I subset datapath (lw, sw, R-type ALU,
// I-type ALU, beq, jal). A Moore FSM sequences each instruction through
// fetch, decode and the execute/memory/writeback steps. Two small
// combinational decoders sit beside it:
//   - the ALU decoder maps the FSM's internal ALUOp, together with funct3,
//     op[5] and funct7b5, to ALUControl;
//   - the immediate decoder maps the opcode to ImmSrc.
//
// Ports
//   clk        : clock, rising-edge active
//   rst_n      : asynchronous active-low reset; forces the FETCH state
//   op         : opcode, instr[6:0]
//   funct3     : instr[14:12]
//   funct7b5   : instr[30]
//   Zero       : ALU zero flag, used for the beq PC update
//   PCWrite    : PC register enable
//   AdrSrc     : memory address select (0 = PC, 1 = ALUOut)
//   MemWrite   : data memory write enable
//   IRWrite    : instruction register write enable
//   RegWrite   : register file write enable
//   ResultSrc  : result select (00 = ALUOut, 01 = Data, 10 = ALUResult)
//   ALUSrcA    : ALU A select (00 = PC, 01 = OldPC, 10 = RD1)
//   ALUSrcB    : ALU B select (00 = RD2, 01 = ImmExt, 10 = constant 4)
//   ImmSrc     : immediate format (00 = I, 01 = S, 10 = B, 11 = J)
//   ALUControl : ALU operation (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   IllegalOp  : one-cycle pulse in DECODE when the opcode is unsupported
//   State      : current FSM state, for debug
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t  state_q, state_d;
  alu_op_t alu_op;
  logic    branch;
  logic    pc_update;

  // NOTE: the state register is the only flop; it resets asynchronously so
  // FETCH is reached the instant rst_n falls, without waiting for a clock.
  // Sequential state is assigned with <= so every flop samples pre-edge
  // values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic and Moore outputs.
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch; it also makes any
  // output not named for a state read as 0.
  always_comb begin
    state_d   = S_FETCH;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    branch    = 1'b0;
    pc_update = 1'b0;
    IllegalOp = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // Computes the branch target OldPC + imm ahead of a possible beq.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d   = S_FETCH;
            IllegalOp = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        // Link value PC+4 is formed from OldPC; the jump target computed in
        // DECODE is already sitting in ALUOut and is loaded into the PC here.
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Branch resolves in the same cycle the ALU reports Zero.
  assign PCWrite = pc_update | (branch & Zero);
  assign State   = state_q;

  // ALU decoder.
  always_comb begin
    ALUControl = 3'b000;
    unique case (alu_op)
      ALUOP_ADD: ALUControl = 3'b000;
      ALUOP_SUB: ALUControl = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          // op[5] separates R-type from I-type, so addi with instr[30] set
          // still adds.
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format decoder.
  always_comb begin
    case (op)
      OP_LW, OP_ITYPE: ImmSrc = 2'b00;
      OP_SW:           ImmSrc = 2'b01;
      OP_BEQ:          ImmSrc = 2'b10;
      OP_JAL:          ImmSrc = 2'b11;
      default:         ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Drives directed and random instruction streams into multicycle_controller
// and compares every cycle against a reference model. The model describes
// each instruction as the list of steps it walks through, and each step as
// the datapath actions that step performs.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       IllegalOp;
  logic [3:0] State;

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .IllegalOp  (IllegalOp),
    .State      (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step numbers as seen on the State port.
  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4,
                 MEMWRITE = 5, EXECUTER = 6, EXECUTEI = 7, ALUWB = 8,
                 BEQ = 9, JAL = 10;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  localparam logic [2:0] A_ADD = 3'b000, A_SUB = 3'b001, A_AND = 3'b010,
                         A_OR = 3'b011, A_SLT = 3'b101;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] res;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] imm;
    logic [2:0] aluc;
    logic       ill;
    logic [3:0] st;
  } ctl_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic is_legal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) ||
           (o == BQ) || (o == JL);
  endfunction

  // Steps an instruction visits, in order, for a given opcode.
  function automatic void steps_for(input logic [6:0] o, output int q[$]);
    q = {};
    case (o)
      LW:      q = '{FETCH, DECODE, MEMADR, MEMREAD, MEMWB};
      SW:      q = '{FETCH, DECODE, MEMADR, MEMWRITE};
      RT:      q = '{FETCH, DECODE, EXECUTER, ALUWB};
      IT:      q = '{FETCH, DECODE, EXECUTEI, ALUWB};
      BQ:      q = '{FETCH, DECODE, BEQ};
      JL:      q = '{FETCH, DECODE, JAL, ALUWB};
      default: q = '{FETCH, DECODE};
    endcase
  endfunction

  // Operation an ALU-type instruction asks for.
  function automatic logic [2:0] alu_func(input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7);
    if (f3 == 3'b000)      return (o == RT && f7) ? A_SUB : A_ADD;
    else if (f3 == 3'b010) return A_SLT;
    else if (f3 == 3'b110) return A_OR;
    else if (f3 == 3'b111) return A_AND;
    else                   return A_ADD;
  endfunction

  function automatic logic [1:0] imm_fmt(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  // Expected outputs for step st of an instruction.
  function automatic logic [31:0] model(input int st, input logic [6:0] o,
                                        input logic [2:0] f3, input logic f7,
                                        input logic z);
    ctl_t e;
    e      = '0;
    e.st   = 4'(st);
    e.imm  = imm_fmt(o);
    e.aluc = A_ADD;
    case (st)
      FETCH:    begin e.irw = 1; e.srcb = 2'b10; e.res = 2'b10; e.pcw = 1; end
      DECODE:   begin e.srca = 2'b01; e.srcb = 2'b01; e.ill = !is_legal(o); end
      MEMADR:   begin e.srca = 2'b10; e.srcb = 2'b01; end
      MEMREAD:  begin e.adr = 1; end
      MEMWB:    begin e.res = 2'b01; e.rw = 1; end
      MEMWRITE: begin e.adr = 1; e.mw = 1; end
      EXECUTER: begin e.srca = 2'b10; e.aluc = alu_func(o, f3, f7); end
      EXECUTEI: begin e.srca = 2'b10; e.srcb = 2'b01; e.aluc = alu_func(o, f3, f7); end
      ALUWB:    begin e.rw = 1; end
      BEQ:      begin e.srca = 2'b10; e.aluc = A_SUB; e.pcw = z; end
      JAL:      begin e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1; end
      default:  e = '0;
    endcase
    return {11'd0, e};
  endfunction

  function automatic logic [31:0] observed_ctl();
    ctl_t c;
    c.pcw  = PCWrite;
    c.adr  = AdrSrc;
    c.mw   = MemWrite;
    c.irw  = IRWrite;
    c.rw   = RegWrite;
    c.res  = ResultSrc;
    c.srca = ALUSrcA;
    c.srcb = ALUSrcB;
    c.imm  = ImmSrc;
    c.aluc = ALUControl;
    c.ill  = IllegalOp;
    c.st   = State;
    return {11'd0, c};
  endfunction

  // One clock of an instruction: drive Zero, check at the falling edge,
  // then advance past the next rising edge. zmode: 0/1 fixed, 2 random.
  task automatic step(input string tag, input int st, input int zmode);
    logic z;
    z    = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
    Zero = z;
    @(negedge clk);
    check($sformatf("%s st%0d", tag, st), observed_ctl(),
          model(st, op, funct3, funct7b5, z));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [6:0] o,
                           input logic [2:0] f3, input logic f7, input int zmode);
    int q[$];
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    steps_for(o, q);
    foreach (q[i]) step(tag, q[i], zmode);
  endtask

  initial begin
    logic [6:0] rop;
    int         kind;

    rst_n    = 1'b0;
    op       = 7'($urandom);
    funct3   = 3'($urandom);
    funct7b5 = 1'b1;
    Zero     = 1'b1;

    // Held in FETCH through reset regardless of clocks or inputs.
    repeat (2) begin
      @(negedge clk);
      check("reset_hold", observed_ctl(), model(FETCH, op, funct3, funct7b5, Zero));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed cases.
    run_instr("sub",      RT, 3'b000, 1'b1, 2);
    run_instr("lw",       LW, 3'b010, 1'b0, 2);
    run_instr("beq_z1",   BQ, 3'b000, 1'b0, 1);
    run_instr("beq_z0",   BQ, 3'b000, 1'b0, 0);
    run_instr("illegal",  7'b1111111, 3'b000, 1'b0, 2);
    run_instr("jal",      JL, 3'b101, 1'b1, 2);
    run_instr("ori",      IT, 3'b110, 1'b1, 2);
    run_instr("addi_f7",  IT, 3'b000, 1'b1, 2);
    run_instr("sw",       SW, 3'b010, 1'b0, 2);

    // Reset asserted in the middle of MEMWB of a load.
    op = LW; funct3 = 3'b010; funct7b5 = 1'b0;
    step("lw_rst", FETCH, 2);
    step("lw_rst", DECODE, 2);
    step("lw_rst", MEMADR, 2);
    step("lw_rst", MEMREAD, 2);
    #1;
    check("pre_rst_state", 32'(State), 32'(MEMWB));
    check("pre_rst_regwrite", 32'(RegWrite), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(State), 32'(FETCH));
    check("async_rst_regwrite", 32'(RegWrite), 32'd0);
    check("async_rst_irwrite", 32'(IRWrite), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_low_hold", observed_ctl(), model(FETCH, op, funct3, funct7b5, Zero));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr("after_rst", RT, 3'b111, 1'b0, 2);

    // Random instruction stream.
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0: rop = LW;
        1: rop = SW;
        2: rop = RT;
        3: rop = IT;
        4: rop = BQ;
        5: rop = JL;
        default: begin
          do rop = 7'($urandom); while (is_legal(rop));
        end
      endcase
      run_instr("rand", rop, 3'($urandom), 1'($urandom_range(0, 1)), 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
